uart_tx_buffered: RTL and testbench

Buffered asynchronous serial transmitter that consumes the per-character `start`/`data` pair produced by the word-output stage and shifts each byte out on a single line. It sits directly downstream of the word/character generator and upstream of the board's serial pin. A small FIFO absorbs characters that arrive while a frame is still on the line. It also reports overflow and busy status back to the producer.

---
 rtl/uart_pkg.sv | 16 +
 rtl/sync_fifo.sv | 54 +++++
 rtl/uart_tx_buffered.sv | 136 +++++++++++++
 tb/tb_uart_tx_buffered.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default baud divisor,
// also reused by the word-output stage for its character pulse spacing.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // 100 MHz system clock / 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is
// accepted only when a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     sysclk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge sysclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO of pending characters feeding a
// start/data/parity/stop framing FSM with a registered serial output.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_EN    = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          sysclk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [7:0]                    data,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [2:0]                    fsm_state
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  uart_state_e   state, state_d;
  logic [BW-1:0] baud, baud_d;
  logic [2:0]    bit_idx, bit_d;
  logic [7:0]    shift, shift_d;
  logic          par, par_d;
  logic          tx_d;
  logic          pop;
  logic          wrap;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;

  // Write handshake: start is a valid strobe with no ready; a byte offered
  // while the FIFO is full and not popping is dropped and flagged next cycle.
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .push   (start),
    .din    (data),
    .pop    (pop),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign wrap      = (baud == BAUD_LAST);
  assign fsm_state = state;

  always_comb begin
    state_d = state;
    baud_d  = wrap ? '0 : baud + 1'b1;
    bit_d   = bit_idx;
    shift_d = shift;
    par_d   = par;
    pop     = 1'b0;
    case (state)
      ST_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          par_d   = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (wrap) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (wrap) begin
          par_d   = par ^ shift[0];
          shift_d = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_idx + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (wrap) begin
          state_d = ST_STOP;
          bit_d   = '0;
        end
      end
      ST_STOP: begin
        if (wrap) begin
          if (bit_idx == STOP_LAST) state_d = ST_IDLE;
          else                      bit_d   = bit_idx + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The line level is a function of the next state so tx can be a flop.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      par      <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_d;
      baud     <= baud_d;
      bit_idx  <= bit_d;
      shift    <= shift_d;
      par      <= par_d;
      tx       <= tx_d;
      busy     <= (state != ST_IDLE) | (fifo_count != '0);
      overflow <= start & fifo_full & ~pop;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: an 8N1 and an 8E2 instance share stimulus and
// are checked every cycle against a queue-based frame model plus literals.
module tb_uart_tx_buffered;

  localparam int C     = 8;
  localparam int DEPTH = 4;

  logic       sysclk = 1'b0;
  logic       rst_n  = 1'b0;
  logic       start  = 1'b0;
  logic [7:0] data   = 8'h00;

  logic [1:0] tx_o;
  logic [1:0] busy_o;
  logic [1:0] ovf_o;
  logic [2:0] cnt_o [2];
  logic [2:0] st_o  [2];

  always #5 sysclk = ~sysclk;

  uart_tx_buffered #(.CLKS_PER_BIT(C), .STOP_BITS(1), .PARITY_EN(0), .FIFO_DEPTH(DEPTH)) dut_a (
    .sysclk(sysclk), .rst_n(rst_n), .start(start), .data(data),
    .tx(tx_o[0]), .busy(busy_o[0]), .overflow(ovf_o[0]),
    .fifo_count(cnt_o[0]), .fsm_state(st_o[0])
  );

  uart_tx_buffered #(.CLKS_PER_BIT(C), .STOP_BITS(2), .PARITY_EN(1), .FIFO_DEPTH(DEPTH)) dut_b (
    .sysclk(sysclk), .rst_n(rst_n), .start(start), .data(data),
    .tx(tx_o[1]), .busy(busy_o[1]), .overflow(ovf_o[1]),
    .fifo_count(cnt_o[1]), .fsm_state(st_o[1])
  );

  int n_cmp = 0;
  int n_bad = 0;
  int now   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] fq    [2][$];
  logic [0:0] exp_q [2][$];
  logic [1:0] exp_tx   = 2'b11;
  logic [1:0] exp_busy = 2'b00;
  logic [1:0] exp_ovf  = 2'b00;
  int         exp_cnt [2] = '{0, 0};

  function automatic void push_level(input int k, input logic v);
    for (int i = 0; i < C; i++) exp_q[k].push_back(v);
  endfunction

  // Whole frame as one level per clock: start, data LSB first, parity, stops.
  function automatic void load_frame(input int k, input logic [7:0] b);
    push_level(k, 1'b0);
    for (int i = 0; i < 8; i++) push_level(k, b[i]);
    if (k == 1) push_level(k, ^b);
    for (int s = 0; s < ((k == 1) ? 2 : 1); s++) push_level(k, 1'b1);
  endfunction

  always @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        fq[k].delete();
        exp_q[k].delete();
        exp_cnt[k] = 0;
      end
      exp_tx   = 2'b11;
      exp_busy = 2'b00;
      exp_ovf  = 2'b00;
    end else begin
      for (int k = 0; k < 2; k++) begin
        int   cb;
        logic idle_now, popd, acc;
        cb       = fq[k].size();
        idle_now = (exp_q[k].size() == 0);
        if (!idle_now) void'(exp_q[k].pop_front());
        popd = idle_now && (cb > 0);
        acc  = start && ((cb < DEPTH) || popd);
        if (popd) load_frame(k, fq[k].pop_front());
        if (acc) fq[k].push_back(data);
        exp_tx[k]   = (exp_q[k].size() > 0) ? exp_q[k][0] : 1'b1;
        exp_cnt[k]  = fq[k].size();
        exp_ovf[k]  = start && !acc;
        exp_busy[k] = !idle_now || (cb != 0);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge sysclk) begin
    for (int k = 0; k < 2; k++) begin
      check((k == 0) ? "model_tx_a"   : "model_tx_b",   int'(tx_o[k]),   int'(exp_tx[k]));
      check((k == 0) ? "model_busy_a" : "model_busy_b", int'(busy_o[k]), int'(exp_busy[k]));
      check((k == 0) ? "model_ovf_a"  : "model_ovf_b",  int'(ovf_o[k]),  int'(exp_ovf[k]));
      check((k == 0) ? "model_cnt_a"  : "model_cnt_b",  int'(cnt_o[k]),  exp_cnt[k]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge sysclk);
    #1;
    now++;
  endtask

  task automatic tick_to(input int target);
    while (now < target) tick();
  endtask

  task automatic drive_start(input logic [7:0] b);
    start = 1'b1;
    data  = b;
    tick();
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while ((busy_o != 2'b00) && (guard < 3000)) begin
      tick();
      guard++;
    end
    check(name, int'(busy_o), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         n0;
    logic [9:0] pat_a;

    #1;
    repeat (3) tick();
    check("rst_tx", int'(tx_o), 3);
    check("rst_busy", int'(busy_o), 0);
    check("rst_ovf", int'(ovf_o), 0);
    check("rst_cnt_a", int'(cnt_o[0]), 0);
    check("rst_state_a", int'(st_o[0]), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Single 8'h41 frame
    pat_a = 10'b1_01000001_0;
    n0 = now;
    drive_start(8'h41);
    check("t1_cnt_n1", int'(cnt_o[0]), 1);
    tick();
    check("t1_tx_fall", int'(tx_o[0]), 0);
    check("t1_cnt_n2", int'(cnt_o[0]), 0);
    for (int i = 0; i < 10; i++) begin
      tick_to(n0 + 2 + 8 * i + 4);
      check("t1_bit_a", int'(tx_o[0]), int'(pat_a[i]));
    end
    check("t1_par_b", int'(tx_o[1]), 0);
    tick_to(n0 + 82);
    check("t1_busy_hold_a", int'(busy_o[0]), 1);
    tick();
    check("t1_busy_fall_a", int'(busy_o[0]), 0);
    tick_to(n0 + 98);
    check("t1_busy_hold_b", int'(busy_o[1]), 1);
    tick();
    check("t1_busy_fall_b", int'(busy_o[1]), 0);
    repeat (3) tick();

    // 8'h07 on the parity / two-stop instance
    n0 = now;
    drive_start(8'h07);
    tick_to(n0 + 2 + 71);
    check("t2_bit7_b", int'(tx_o[1]), 0);
    tick_to(n0 + 2 + 76);
    check("t2_par_b", int'(tx_o[1]), 1);
    tick_to(n0 + 2 + 80);
    check("t2_stop1_b", int'(tx_o[1]), 1);
    tick_to(n0 + 2 + 95);
    check("t2_stop2_b", int'(tx_o[1]), 1);
    check("t2_busy_end_b", int'(busy_o[1]), 1);
    tick_to(n0 + 99);
    check("t2_busy_fall_b", int'(busy_o[1]), 0);
    repeat (3) tick();

    // Burst of six writes, then a write on the IDLE pop cycle of dut_a
    n0 = now;
    for (int i = 0; i < 6; i++) begin
      start = 1'b1;
      data  = 8'h30 + 8'(i);
      tick();
      if (i == 4) begin
        check("t3_cnt_full", int'(cnt_o[0]), 4);
        check("t3_no_ovf", int'(ovf_o), 0);
      end
    end
    start = 1'b0;
    check("t3_ovf_pulse", int'(ovf_o), 3);
    tick();
    check("t3_ovf_clear", int'(ovf_o), 0);
    tick_to(n0 + 82);
    drive_start(8'h36);
    check("t3_popfull_cnt_a", int'(cnt_o[0]), 4);
    check("t3_popfull_ovf_a", int'(ovf_o[0]), 0);
    check("t3_full_drop_b", int'(ovf_o[1]), 1);
    drain("t3_drain");

    // Randomized traffic with periodic bursts
    for (int c = 0; c < 3000; c++) begin
      start = ((c % 700) < 6) || ($urandom_range(0, 99) < 3);
      data  = 8'($urandom_range(0, 255));
      tick();
    end
    start = 1'b0;
    drain("rand_drain");

    // Asynchronous reset in the middle of data bit 3
    n0 = now;
    drive_start(8'h55);
    drive_start(8'hAA);
    tick_to(n0 + 37);
    check("t5_bit3_a", int'(tx_o[0]), 0);
    check("t5_cnt_pre", int'(cnt_o[0]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_tx_async", int'(tx_o), 3);
    check("t5_cnt_async", int'(cnt_o[0]), 0);
    check("t5_busy_async", int'(busy_o), 0);
    check("t5_state_async", int'(st_o[1]), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick_to(now + 200);
    check("t5_idle_tx", int'(tx_o), 3);
    check("t5_idle_busy", int'(busy_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
